// File: rtl/fdtd_pkg.sv
// Shared mode encoding and default widths for the FDTD update datapath.
package fdtd_pkg;

    localparam int FDTD_W    = 32;
    localparam int FDTD_FRAC = 20;

    typedef enum logic [1:0] {
        MODE_HY     = 2'b00,
        MODE_EZ     = 2'b01,
        MODE_EZ_SRC = 2'b10,
        MODE_PASS   = 2'b11
    } fdtd_mode_e;

endpackage

// File: rtl/fdtd_lane_mac.sv
// One lane of the S1..S3 update datapath: neighbour difference, three signed products,
// sum + rescale, optional clamp. Advances only when en is high; clamp flags the S2->S3 move.
module fdtd_lane_mac #(
    parameter int W      = 32,
    parameter int FRAC   = 20,
    parameter int SAT_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] f_old,
    input  logic signed [W-1:0] nb_hi,
    input  logic signed [W-1:0] nb_lo,
    input  logic signed [W-1:0] c_self,
    input  logic signed [W-1:0] c_curl,
    input  logic signed [W-1:0] cezj,
    input  logic signed [W-1:0] jz,
    input  logic                inj,
    input  logic                pass,
    output logic [W-1:0]        f_new,
    output logic                clamp
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 3;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic signed [W-1:0]  f1, f2;
    logic signed [W:0]    d1;
    logic signed [PW-1:0] ps2, pj2;
    logic signed [PW:0]   pc2;
    logic signed [SW-1:0] sum, r;
    logic [W-1:0]         nxt;

    assign sum = SW'(ps2) + SW'(pc2) + SW'(pj2);
    assign r   = sum >>> FRAC;

    always_comb begin
        clamp = 1'b0;
        nxt   = r[W-1:0];
        if (pass) begin
            nxt = f2;
        end else if (SAT_EN != 0) begin
            if (r > MAX_V) begin
                nxt   = MAX_V[W-1:0];
                clamp = 1'b1;
            end else if (r < MIN_V) begin
                nxt   = MIN_V[W-1:0];
                clamp = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1    <= '0;
            d1    <= '0;
            f2    <= '0;
            ps2   <= '0;
            pc2   <= '0;
            pj2   <= '0;
            f_new <= '0;
        end else if (en) begin
            // W+1 bits so hi-lo never overflows
            f1    <= f_old;
            d1    <= (W+1)'(nb_hi) - (W+1)'(nb_lo);
            f2    <= f1;
            ps2   <= PW'(c_self) * PW'(f1);
            pc2   <= (PW+1)'(c_curl) * (PW+1)'(d1);
            if (inj) pj2 <= PW'(cezj) * PW'(jz);
            else     pj2 <= '0;
            f_new <= nxt;
        end
    end

endmodule

// File: rtl/fdtd_update_pipe.sv
// LANES-wide FDTD field update, 3-cycle latency, valid/ready with whole-pipe freeze on stall.
// Also counts beats in which any lane saturated (sticky at 0xFFFF, clearable).
module fdtd_update_pipe
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = FDTD_W,
    parameter int FRAC_BITS       = FDTD_FRAC,
    parameter int LANES           = 1,
    parameter int SAT_EN          = 1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic [1:0]                       mode_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [FDTD_DATA_WIDTH-1:0]       c_self_i,
    input  logic [FDTD_DATA_WIDTH-1:0]       c_curl_i,
    input  logic [FDTD_DATA_WIDTH-1:0]       cezj_i,
    input  logic [FDTD_DATA_WIDTH-1:0]       jz_i,
    input  logic [$clog2(LANES):0]           src_lane_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0] f_old_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0] nb_hi_i,
    input  logic [LANES*FDTD_DATA_WIDTH-1:0] nb_lo_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [LANES*FDTD_DATA_WIDTH-1:0] f_new_o,
    output logic [1:0]                       mode_o,
    output logic [15:0]                      sat_cnt_o,
    input  logic                             sat_clr_i
);

    localparam int W   = FDTD_DATA_WIDTH;
    localparam int SLW = $clog2(LANES) + 1;

    logic             v1, v2, v3;
    logic             stall, adv;
    fdtd_mode_e       mode1, mode2;
    logic [SLW-1:0]   src1;
    logic [W-1:0]     cself1, ccurl1, cezj1, jz1;
    logic [LANES-1:0] clamp;

    assign out_valid_o = v3;
    assign stall       = v3 && !out_ready_i;
    assign adv         = !stall;
    assign in_ready_o  = !stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            mode1  <= MODE_HY;
            mode2  <= MODE_HY;
            mode_o <= 2'b00;
            src1   <= '0;
            cself1 <= '0;
            ccurl1 <= '0;
            cezj1  <= '0;
            jz1    <= '0;
        end else if (adv) begin
            v1     <= in_valid_i;
            v2     <= v1;
            v3     <= v2;
            mode1  <= fdtd_mode_e'(mode_i);
            mode2  <= mode1;
            mode_o <= mode2;
            src1   <= src_lane_i;
            cself1 <= c_self_i;
            ccurl1 <= c_curl_i;
            cezj1  <= cezj_i;
            jz1    <= jz_i;
        end
    end

    // One count per beat, however many lanes clamped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sat_cnt_o <= '0;
        end else if (sat_clr_i) begin
            sat_cnt_o <= '0;
        end else if (adv && v2 && (|clamp) && (sat_cnt_o != 16'hFFFF)) begin
            sat_cnt_o <= sat_cnt_o + 16'd1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fdtd_lane_mac #(
            .W      (W),
            .FRAC   (FRAC_BITS),
            .SAT_EN (SAT_EN)
        ) u_mac (
            .clk    (CLK),
            .rst_n  (RST_N),
            .en     (adv),
            .f_old  (f_old_i[k*W +: W]),
            .nb_hi  (nb_hi_i[k*W +: W]),
            .nb_lo  (nb_lo_i[k*W +: W]),
            .c_self (cself1),
            .c_curl (ccurl1),
            .cezj   (cezj1),
            .jz     (jz1),
            .inj    ((mode1 == MODE_EZ_SRC) && (src1 == SLW'(k))),
            .pass   (mode2 == MODE_PASS),
            .f_new  (f_new_o[k*W +: W]),
            .clamp  (clamp[k])
        );
    end

endmodule

// File: tb/tb_fdtd_update_pipe.sv
// Scoreboard bench: a 2-lane saturating pipe for the main tests and a 1-lane wrapping pipe for the boundary case.
module tb_fdtd_update_pipe;

    typedef struct {
        logic [63:0] f;
        logic [1:0]  m;
        int          iss;
        bit          lat;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [1:0]  mode = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1, sat_clr = 0;
    logic [31:0] c_self = 0, c_curl = 0, cezj = 0, jz = 0;
    logic [1:0]  src_lane = 0;
    logic [63:0] f_old = 0, nb_hi = 0, nb_lo = 0, f_new;
    logic [1:0]  mode_o;
    logic [15:0] sat_cnt;

    logic [1:0]  mode_b = 0;
    logic        in_valid_b = 0, in_ready_b, out_valid_b;
    logic        out_ready_b = 1, sat_clr_b = 0;
    logic [31:0] c_self_b = 0, c_curl_b = 0, cezj_b = 0, jz_b = 0;
    logic [0:0]  src_lane_b = 1'b1;
    logic [31:0] f_old_b = 0, nb_hi_b = 0, nb_lo_b = 0, f_new_b;
    logic [1:0]  mode_o_b;
    logic [15:0] sat_cnt_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    bit          prev_stall = 0;
    logic [63:0] prev_f;
    logic [1:0]  prev_m;
    int          stall_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdtd_update_pipe #(.FDTD_DATA_WIDTH(32), .FRAC_BITS(20), .LANES(2), .SAT_EN(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .c_self_i(c_self), .c_curl_i(c_curl), .cezj_i(cezj), .jz_i(jz), .src_lane_i(src_lane),
        .f_old_i(f_old), .nb_hi_i(nb_hi), .nb_lo_i(nb_lo), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .f_new_o(f_new), .mode_o(mode_o), .sat_cnt_o(sat_cnt),
        .sat_clr_i(sat_clr)
    );

    fdtd_update_pipe #(.FDTD_DATA_WIDTH(32), .FRAC_BITS(20), .LANES(1), .SAT_EN(0)) dut_b (
        .CLK(clk), .RST_N(rst_n), .mode_i(mode_b), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .c_self_i(c_self_b), .c_curl_i(c_curl_b), .cezj_i(cezj_b), .jz_i(jz_b), .src_lane_i(src_lane_b),
        .f_old_i(f_old_b), .nb_hi_i(nb_hi_b), .nb_lo_i(nb_lo_b), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready_b), .f_new_o(f_new_b), .mode_o(mode_o_b), .sat_cnt_o(sat_cnt_b),
        .sat_clr_i(sat_clr_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] cs, input logic [31:0] cc,
                        input logic [31:0] cj, input logic [31:0] j, input logic [1:0] sl,
                        input logic [63:0] fo, input logic [63:0] hi, input logic [63:0] lo,
                        input logic [63:0] ef, input bit lat);
        int n = 0;
        mode = m; c_self = cs; c_curl = cc; cezj = cj; jz = j; src_lane = sl;
        f_old = fo; nb_hi = hi; nb_lo = lo; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 100), 1);
        qa.push_back('{ef, m, cyc, lat});
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic send_b(input logic [1:0] m, input logic [31:0] cs, input logic [31:0] cc,
                          input logic [31:0] fo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] ef);
        mode_b = m; c_self_b = cs; c_curl_b = cc; f_old_b = fo; nb_hi_b = hi; nb_lo_b = lo;
        in_valid_b = 1;
        @(negedge clk);
        check("b_in_ready", in_ready_b, 1);
        qb.push_back('{64'(ef), m, cyc, 1'b1});
        @(posedge clk);
        #1 in_valid_b = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 200), 1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_f_new", f_new, prev_f);
                check("hold_mode", mode_o, prev_m);
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                check("in_ready_stall", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    check("spurious_a", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    check("f_new", f_new, ea.f);
                    check("mode_o", mode_o, ea.m);
                    if (ea.lat) check("latency", 64'(cyc - ea.iss), 3);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_f     = f_new;
            prev_m     = mode_o;
            if (out_valid_b) begin
                if (qb.size() == 0) begin
                    check("spurious_b", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_f_new", 64'(f_new_b), eb.f);
                    check("b_latency", 64'(cyc - eb.iss), 3);
                end
            end
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_f_new", f_new, 0);
        check("rst_mode_o", mode_o, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Hy update, Ez update with negative values, floor rounding of -1 LSB
        send(2'b00, 32'h0010_0000, 32'h0008_0000, 0, 0, 2'd2, {2{32'h0020_0000}},
             {2{32'h0030_0000}}, {2{32'h0010_0000}}, {2{32'h0030_0000}}, 1);
        send(2'b01, 32'h0008_0000, 32'h0010_0000, 0, 0, 2'd2, {32'hFFC0_0000, 32'h0040_0000},
             {32'h0000_0000, 32'h0010_0000}, {32'h0010_0000, 32'h0030_0000},
             {32'hFFD0_0000, 32'h0000_0000}, 1);
        send(2'b00, 32'h0000_0001, 0, 0, 0, 2'd2, {32'h0000_0001, 32'hFFFF_FFFF}, 0, 0,
             {32'h0000_0000, 32'hFFFF_FFFF}, 1);
        drain();

        // Source injection: lane 0, lane 1, out-of-range lane, non-source mode
        send(2'b10, 32'h0010_0000, 0, 32'hFFF0_0000, 32'h0010_0000, 2'd0, {2{32'h0040_0000}},
             0, 0, {32'h0040_0000, 32'h0030_0000}, 1);
        send(2'b10, 32'h0010_0000, 0, 32'hFFF0_0000, 32'h0010_0000, 2'd1, {2{32'h0040_0000}},
             0, 0, {32'h0030_0000, 32'h0040_0000}, 1);
        send(2'b10, 32'h0010_0000, 0, 32'hFFF0_0000, 32'h0010_0000, 2'd2, {2{32'h0040_0000}},
             0, 0, {2{32'h0040_0000}}, 1);
        send(2'b01, 32'h0010_0000, 0, 32'hFFF0_0000, 32'h0010_0000, 2'd0, {2{32'h0040_0000}},
             0, 0, {2{32'h0040_0000}}, 1);
        drain();

        // Saturation both directions, clear, passthrough never counts
        send(2'b01, 32'h7FFF_FFFF, 0, 0, 0, 2'd2, {2{32'h7FFF_FFFF}}, 0, 0,
             {2{32'h7FFF_FFFF}}, 1);
        drain();
        check("sat_cnt_1", sat_cnt, 1);
        send(2'b01, 32'h7FFF_FFFF, 0, 0, 0, 2'd2, {2{32'h8000_0001}}, 0, 0,
             {2{32'h8000_0000}}, 1);
        drain();
        check("sat_cnt_2", sat_cnt, 2);
        sat_clr = 1;
        @(posedge clk);
        #1 sat_clr = 0;
        check("sat_cnt_clr", sat_cnt, 0);
        send(2'b11, 32'h7FFF_FFFF, 0, 0, 0, 2'd2, {2{32'h7FFF_FFFF}}, 0, 0,
             {2{32'h7FFF_FFFF}}, 1);
        drain();
        check("sat_cnt_pass", sat_cnt, 0);

        // Backpressure: 10 passthrough beats, 5-cycle downstream stall
        fork
            for (int k = 1; k <= 10; k++)
                send(2'b11, 0, 0, 0, 0, 2'd2, {32'(k + 100), 32'(k)}, 0, 0,
                     {32'(k + 100), 32'(k)}, 0);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        check("stall_seen", 64'(stall_seen), 5);

        // Reset with three beats in flight, the oldest a saturating one
        send(2'b01, 32'h7FFF_FFFF, 0, 0, 0, 2'd2, {2{32'h7FFF_FFFF}}, 0, 0, 0, 0);
        send(2'b00, 32'h0010_0000, 0, 0, 0, 2'd2, {2{32'h0000_0005}}, 0, 0, 0, 0);
        send(2'b00, 32'h0010_0000, 0, 0, 0, 2'd2, {2{32'h0000_0006}}, 0, 0, 0, 0);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sat", sat_cnt, 1);
        rst_n = 0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sat", sat_cnt, 0);
        check("mid_rst_f_new", f_new, 0);
        check("mid_rst_mode", mode_o, 0);
        qa.delete();
        @(posedge clk);
        #3 rst_n = 1;
        repeat (8) @(posedge clk);
        #1;
        send(2'b01, 32'h0010_0000, 0, 0, 0, 2'd2, {32'h0000_0009, 32'h0000_0007}, 0, 0,
             {32'h0000_0009, 32'h0000_0007}, 1);
        drain();

        // Wrapping instance: wide diff, wrapped products, counter idle
        send_b(2'b01, 0, 32'h0010_0000, 0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);
        send_b(2'b01, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 0, 32'hFFFF_F000);
        send_b(2'b00, 32'h7FFF_FFFF, 0, 32'h8000_0001, 0, 0, 32'h0000_0FFF);
        drain();
        check("b_sat_cnt", sat_cnt_b, 0);
        check("qa_empty", 64'(qa.size()), 0);
        check("qb_empty", 64'(qb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
